// File: rtl/matrix_pkg.sv
// Shared constants, size encodings, FSM states and frame cell addressing
// for the matrix loader and its row/column counter.
package matrix_pkg;

    localparam int EW      = 8;
    localparam int NMAX    = 4;
    localparam int FRAME_W = NMAX * NMAX * EW;

    localparam logic [1:0] SZ_2X2  = 2'd0;
    localparam logic [1:0] SZ_3X3  = 2'd1;
    localparam logic [1:0] SZ_4X4  = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_e;

    // LSB of cell (r,c) in the row-major frame: element (0,0) sits in the top byte.
    function automatic logic [6:0] cell_lsb(input logic [1:0] r, input logic [1:0] c);
        return 7'd120 - {r, 5'b00000} - {2'b00, c, 3'b000};
    endfunction

endpackage

// File: rtl/matrix_loader_ctr.sv
// Row/column element counter for an N x N load (N = order + 2); raises
// last_o while pointing at the bottom-right cell.
module matrix_loader_ctr (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       adv_i,
    input  logic [1:0] order_i,
    output logic [1:0] row_o,
    output logic [1:0] col_o,
    output logic       last_o
);

    logic [1:0] row_q;
    logic [1:0] col_q;
    logic [1:0] lim_s;

    assign lim_s  = order_i + 2'd1;
    assign last_o = (row_q == lim_s) && (col_q == lim_s);
    assign row_o  = row_q;
    assign col_o  = col_q;

    // Counter state: clear has priority over advance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q <= 2'd0;
            col_q <= 2'd0;
        end else if (clr_i) begin
            row_q <= 2'd0;
            col_q <= 2'd0;
        end else if (adv_i) begin
            if (col_q == lim_s) begin
                col_q <= 2'd0;
                row_q <= last_o ? 2'd0 : row_q + 2'd1;
            end else begin
                col_q <= col_q + 2'd1;
                row_q <= row_q;
            end
        end else begin
            row_q <= row_q;
            col_q <= col_q;
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Assembles streamed elements into a packed 4x4 row-major frame and holds it
// under valid/ready. Optional macro MATRIX_LOADER_TRANSPOSE_EN adds col_major_i.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         size_i,
    input  logic               in_valid_i,
    input  logic [EW-1:0]      in_data_i,
    input  logic               out_ready_i,
`ifdef MATRIX_LOADER_TRANSPOSE_EN
    input  logic               col_major_i,
`endif
    output logic               in_ready_o,
    output logic [FRAME_W-1:0] matrix_o,
    output logic               out_valid_o,
    output logic [1:0]         order_o,
    output logic               size_err_o
);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] matrix_q, matrix_d;
    logic [1:0]         order_q, order_d;
    logic               size_err_q, size_err_d;
    logic               ctr_clr_s, ctr_adv_s, last_s;
    logic [1:0]         row_s, col_s, wr_row_s, wr_col_s;
    logic               start_take_s, in_ready_s, accept_s;

    // A start in FULL only counts when the consumer takes the frame that cycle.
    assign start_take_s = start_i && ((state_q != FULL) || out_ready_i);
    assign in_ready_s   = (state_q == LOAD) && !start_i;
    assign accept_s     = in_ready_s && in_valid_i;

    matrix_loader_ctr u_ctr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (ctr_clr_s),
        .adv_i   (ctr_adv_s),
        .order_i (order_q),
        .row_o   (row_s),
        .col_o   (col_s),
        .last_o  (last_s)
    );

`ifdef MATRIX_LOADER_TRANSPOSE_EN
    logic col_major_q;

    // Input ordering flag, captured alongside the order on an accepted start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_major_q <= 1'b0;
        end else if (start_take_s && (size_i != SZ_RSVD)) begin
            col_major_q <= col_major_i;
        end else begin
            col_major_q <= col_major_q;
        end
    end

    assign wr_row_s = col_major_q ? col_s : row_s;
    assign wr_col_s = col_major_q ? row_s : col_s;
`else
    assign wr_row_s = row_s;
    assign wr_col_s = col_s;
`endif

    // Next-state, frame update and counter control.
    always_comb begin
        state_d    = state_q;
        matrix_d   = matrix_q;
        order_d    = order_q;
        size_err_d = 1'b0;
        ctr_clr_s  = 1'b0;
        ctr_adv_s  = 1'b0;
        if (start_take_s) begin
            if (size_i == SZ_RSVD) begin
                state_d    = IDLE;
                size_err_d = 1'b1;
            end else begin
                state_d   = LOAD;
                matrix_d  = {FRAME_W{1'b0}};
                order_d   = size_i;
                ctr_clr_s = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: begin
                    if (accept_s) begin
                        matrix_d[cell_lsb(wr_row_s, wr_col_s) +: EW] = in_data_i;
                        ctr_adv_s = 1'b1;
                        state_d   = last_s ? FULL : LOAD;
                    end else begin
                        state_d = LOAD;
                    end
                end
                FULL: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, frame and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            matrix_q   <= {FRAME_W{1'b0}};
            order_q    <= 2'd0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            matrix_q   <= matrix_d;
            order_q    <= order_d;
            size_err_q <= size_err_d;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign matrix_o    = matrix_q;
    assign out_valid_o = (state_q == FULL);
    assign order_o     = order_q;
    assign size_err_o  = size_err_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: an index-based reference model checked
// every cycle, plus literal frame expectations from hand-worked loads.
module tb_matrix_loader;
    import matrix_pkg::*;

    logic         clk = 1'b0;
    logic         rst, start, in_valid, out_ready, col_major;
    logic [1:0]   size;
    logic [7:0]   in_data;
    logic         in_ready_o, out_valid_o, size_err_o;
    logic [127:0] matrix_o;
    logic [1:0]   order_o;

    always #5 clk = ~clk;

    matrix_loader dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .size_i      (size),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .out_ready_i (out_ready),
`ifdef MATRIX_LOADER_TRANSPOSE_EN
        .col_major_i (col_major),
`endif
        .in_ready_o  (in_ready_o),
        .matrix_o    (matrix_o),
        .out_valid_o (out_valid_o),
        .order_o     (order_o),
        .size_err_o  (size_err_o)
    );

    int chk  = 0;
    int errs = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: phase 0=idle, 1=loading, 2=frame held.
    int         m_phase, m_n, m_idx;
    logic [7:0] m_cells [16];
    logic [1:0] m_order;
    logic       m_err, m_cm;
    logic [7:0] vals [16];

    function automatic logic [127:0] m_frame();
        logic [127:0] f;
        for (int k = 0; k < 16; k++) f[127-8*k -: 8] = m_cells[k];
        return f;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_n = 2; m_idx = 0; m_order = 2'd0; m_err = 1'b0; m_cm = 1'b0;
        for (int k = 0; k < 16; k++) m_cells[k] = 8'h00;
    endtask

    task automatic tick();
        int r, c, t;
        logic nerr;
        @(posedge clk);
        nerr = 1'b0;
        if (rst) begin
            model_reset();
        end else if (start && (m_phase != 2 || out_ready)) begin
            if (size == 2'd3) begin
                m_phase = 0;
                nerr = 1'b1;
            end else begin
                m_phase = 1; m_n = int'(size) + 2; m_idx = 0; m_order = size; m_cm = col_major;
                for (int k = 0; k < 16; k++) m_cells[k] = 8'h00;
            end
        end else if (m_phase == 1 && in_valid) begin
            r = m_idx / m_n;
            c = m_idx % m_n;
            if (m_cm) begin t = r; r = c; c = t; end
            m_cells[r*4+c] = in_data;
            m_idx++;
            if (m_idx == m_n * m_n) m_phase = 2;
        end else if (m_phase == 2 && out_ready) begin
            m_phase = 0;
        end
        m_err = nerr;
        #1;
    endtask

    always @(negedge clk) begin
        check("in_ready", in_ready_o, (m_phase == 1) && !start);
        check("out_valid", out_valid_o, m_phase == 2);
        check("matrix", matrix_o, m_frame());
        check("order", order_o, m_order);
        check("size_err", size_err_o, m_err);
    end

    task automatic feed(input int cnt);
        int k = 0;
        in_valid = 1'b1;
        for (int b = 0; b < 100 && k < cnt; b++) begin
            in_data = vals[k];
            #1;
            if (in_ready_o) k++;
            tick();
        end
        in_valid = 1'b0;
        check("accept_count", k, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; size = 2'd0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; col_major = 1'b0;
        model_reset();
        tick(); tick();
        check("rst_matrix", matrix_o, 128'h0);
        check("rst_valid", out_valid_o, 1'b0);
        check("rst_ready", in_ready_o, 1'b0);
        check("rst_order", order_o, 2'd0);
        rst = 1'b0;
        tick();

        // 4x4 load of 1..16
        start = 1'b1; size = 2'd2; tick(); start = 1'b0;
        for (int k = 0; k < 16; k++) vals[k] = 8'(k + 1);
        feed(16);
        check("ld4_valid", out_valid_o, 1'b1);
        check("ld4_matrix", matrix_o, 128'h0102030405060708090A0B0C0D0E0F10);
        check("ld4_order", order_o, 2'd2);

        // Handshake, then 2x2 with extreme values, held under back-pressure
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("hs_valid", out_valid_o, 1'b0);
        check("hs_retained", matrix_o, 128'h0102030405060708090A0B0C0D0E0F10);
        start = 1'b1; size = 2'd0; tick(); start = 1'b0;
        vals[0] = 8'h80; vals[1] = 8'h7F; vals[2] = 8'h01; vals[3] = 8'hFF;
        feed(4);
        check("ld2_row0", matrix_o[127:96], 32'h807F0000);
        check("ld2_row1", matrix_o[95:64], 32'h01FF0000);
        check("ld2_rest", matrix_o[63:0], 64'h0);
        in_valid = 1'b1; in_data = 8'h33;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin start = 1'b1; size = 2'd1; end
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        #1;
        check("hold_row0", matrix_o[127:96], 32'h807F0000);
        check("hold_ready", in_ready_o, 1'b0);
        check("hold_valid", out_valid_o, 1'b1);
        check("hold_order", order_o, 2'd0);

        // Back-to-back: start together with out_ready in FULL
        start = 1'b1; size = 2'd1; out_ready = 1'b1; tick(); start = 1'b0; out_ready = 1'b0;
        #1;
        check("b2b_valid", out_valid_o, 1'b0);
        check("b2b_ready", in_ready_o, 1'b1);
        for (int k = 0; k < 9; k++) vals[k] = 8'(k + 1);
        feed(9);
        check("ld3_matrix", matrix_o, 128'h01020300040506000708090000000000);
        check("ld3_order", order_o, 2'd1);

        // Restart mid-load drops the same-cycle element
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        start = 1'b1; size = 2'd2; tick(); start = 1'b0;
        for (int k = 0; k < 16; k++) vals[k] = 8'(8'h21 + k);
        feed(5);
        start = 1'b1; size = 2'd1; in_valid = 1'b1; in_data = 8'h55;
        #1;
        check("rs_ready", in_ready_o, 1'b0);
        tick(); start = 1'b0; in_valid = 1'b0;
        check("rs_cleared", matrix_o, 128'h0);
        check("rs_order", order_o, 2'd1);
        for (int k = 0; k < 9; k++) vals[k] = 8'(8'h11 + k);
        feed(9);
        check("rs_matrix", matrix_o, 128'h11121300141516001718190000000000);

        // Reserved size from IDLE
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        start = 1'b1; size = 2'd3; tick(); start = 1'b0;
        #1;
        check("err_pulse", size_err_o, 1'b1);
        check("err_ready", in_ready_o, 1'b0);
        tick();
        check("err_clear", size_err_o, 1'b0);
        check("err_valid", out_valid_o, 1'b0);

        // Asynchronous reset between edges mid-load
        start = 1'b1; size = 2'd2; tick(); start = 1'b0;
        feed(3);
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_valid", out_valid_o, 1'b0);
        check("arst_ready", in_ready_o, 1'b0);
        check("arst_matrix", matrix_o, 128'h0);
        tick();
        rst = 1'b0;
        tick(); tick();
        #1;
        check("post_rst_ready", in_ready_o, 1'b0);
        check("post_rst_valid", out_valid_o, 1'b0);
        in_valid = 1'b0;

`ifdef MATRIX_LOADER_TRANSPOSE_EN
        // Column-major 2x2 input
        col_major = 1'b1; start = 1'b1; size = 2'd0; tick(); start = 1'b0; col_major = 1'b0;
        for (int k = 0; k < 4; k++) vals[k] = 8'(k + 1);
        feed(4);
        check("tr_row0", matrix_o[127:96], 32'h01030000);
        check("tr_row1", matrix_o[95:64], 32'h02040000);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end

endmodule
